// File: rtl/temp_sample_scheduler.sv
// Round-robin scheduler sharing one temperature calculator among sensor channels.
// Optional sticky over-temperature flags are built when TEMP_ALARM_EN is defined.
module temp_sample_scheduler #(
  parameter int          NUM_CH       = 4,
  parameter int          CH_W         = 2,
  parameter int          CALC_LAT     = 2,
  parameter logic [7:0]  ALARM_THRESH = 8'd100
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_CH-1:0]   req,
  input  logic [4*NUM_CH-1:0] sensor_in,
  output logic [NUM_CH-1:0]   gnt,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [4:0]          cfg_base,
  input  logic [3:0]          cfg_coef,
  output logic [4:0]          calc_base,
  output logic [3:0]          calc_coef,
  output logic [3:0]          calc_sensor,
  input  logic [7:0]          calc_temp,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [7:0]          out_temp,
  output logic                busy,
  output logic [NUM_CH-1:0]   alarm,
  input  logic [NUM_CH-1:0]   alarm_clr
);

  localparam int CNT_W = $clog2(CALC_LAT + 1);
  localparam int SW    = CH_W + 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t state, nextState;

  logic [CNT_W-1:0]    cnt;
  logic [CH_W-1:0]     ptr;
  logic [CH_W-1:0]     curCh;
  logic [CH_W-1:0]     winner;
  logic [CH_W-1:0]     ptrNext;
  logic [CH_W-1:0]     off;
  logic [SW-1:0]       sum;
  logic [2*NUM_CH-1:0] dbl;
  logic [NUM_CH-1:0]   rot;
  logic                found;
  logic                capture;
  logic                finish;
  logic [4:0]          selBase;
  logic [3:0]          selCoef;
  logic [3:0]          selSens;

  logic [4:0] baseReg [NUM_CH];
  logic [3:0] coefReg [NUM_CH];

  // Rotate requests so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NUM_CH-1:0];
    found = |req;
    off   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot[i]) off = CH_W'(i);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= SW'(NUM_CH)) sum = sum - SW'(NUM_CH);
    winner  = sum[CH_W-1:0];
    ptrNext = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
  end

  always_comb begin
    selBase = '0;
    selCoef = '0;
    selSens = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (winner == CH_W'(k)) begin
        selBase = baseReg[k];
        selCoef = coefReg[k];
        selSens = sensor_in[4*k +: 4];
      end
    end
  end

  assign capture = (state == IDLE) && found;
  assign finish  = (state == WAIT) && (cnt == CNT_W'(1));
  assign busy    = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (found)  nextState = WAIT;
      WAIT: if (finish) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Out-of-range channel indices match no register and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        baseReg[k] <= '0;
        coefReg[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cfg_we && cfg_ch == CH_W'(k)) begin
          baseReg[k] <= cfg_base;
          coefReg[k] <= cfg_coef;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      calc_base   <= '0;
      calc_coef   <= '0;
      calc_sensor <= '0;
      cnt         <= '0;
      ptr         <= '0;
      curCh       <= '0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_temp    <= '0;
    end else begin
      gnt       <= '0;
      out_valid <= 1'b0;
      if (capture) begin
        calc_base   <= selBase;
        calc_coef   <= selCoef;
        calc_sensor <= selSens;
        gnt         <= NUM_CH'(1) << winner;
        cnt         <= CNT_W'(CALC_LAT);
        ptr         <= ptrNext;
        curCh       <= winner;
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (finish) begin
        out_temp  <= calc_temp;
        out_ch    <= curCh;
        out_valid <= 1'b1;
      end
    end
  end

`ifdef TEMP_ALARM_EN
  logic [NUM_CH-1:0] setMask;

  always_comb begin
    setMask = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (out_valid && out_temp > ALARM_THRESH && out_ch == CH_W'(k))
        setMask[k] = 1'b1;
    end
  end

  // A set on the same edge as a clear keeps the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm <= '0;
    else        alarm <= (alarm & ~alarm_clr) | setMask;
  end
`else
  logic unusedAlarm;
  assign unusedAlarm = ^{alarm_clr, ALARM_THRESH};
  assign alarm       = '0;
`endif

endmodule
